alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised, multi-cycle successor to the 16-bit combinational datapath ALU. It registers its operands through a valid/ready handshake and executes these operations:
- the eight existing operations (rotate, shift, add, logical) in one cycle;
- a new iterative unsigned multiply (shift-add, one bit per cycle).

The result is held under output backpressure. It sits between decode/register-read and writeback in the execute stage, and stalls the front end via `in_ready` while a multiply is in flight.

## Interface
- `WIDTH`, default 16, datapath width in bits (power of two, ≥8).
- `SHW`, default 4, shift-amount width; must equal log2(WIDTH).
- `clk`  in  1  clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand bundle valid.
- `in_ready`  out  1  block can accept a bundle.
- `A`, `B`  in  WIDTH  operands.
- `Cin`  in  1  adder carry-in.
- `Op`  in  4  opcode: 0 ROL, 1 SLL, 2 ROR, 3 SRA, 4 ADD, 5 OR, 6 XOR, 7 AND, 8 MUL, 9–15 reserved.
- `invA`, `invB`  in  1  invert A / B before use (independent controls).
- `sign`  in  1  selects signed (1) or unsigned (0) overflow for ADD.
- `out_valid`  out  1  result bundle valid.
- `out_ready`  in  1  consumer accepts result.
- `Out`  out  WIDTH  result.
- `OFL`  out  1  overflow flag.
- `Zero`  out  1  Out == 0.
- `err`  out  1  reserved opcode was issued.

## Operation
- Operand transfer happens on a rising edge when `in_valid && in_ready`.
- The block captures `opA = invA ? ~A : A`, `opB = invB ? ~B : B`, `Cin`, `Op` and `sign`.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `in_ready=1`. On accept:
    - Op 8 → BUSY, with bit counter = WIDTH, accumulator = 0, multiplicand register = opA, multiplier register = opB.
    - Any other Op → compute in the same cycle, register the result, go to DONE.
  - BUSY: `in_ready=0`, `out_valid=0`. Each cycle:
    - if multiplier LSB = 1, add multiplicand into the 2·WIDTH accumulator;
    - shift multiplicand left by 1 and multiplier right by 1;
    - decrement counter.
    - When counter reaches 0 → DONE.
  - DONE: `out_valid=1`, `in_ready=0`, all outputs held stable. `out_ready=1` → IDLE next edge.
- Shifts use amount `opB[SHW-1:0]`.
  - ROL/ROR rotate modulo WIDTH.
  - SLL zero-fills.
  - SRA replicates `opA[WIDTH-1]`.
- ADD computes `opA + opB + Cin`, truncated to WIDTH.
  - `OFL = sign ? (opA MSB == opB MSB && Out MSB != opA MSB) : carry-out`.
- Logical ops (OR/XOR/AND) act on opA, opB. `OFL=0`.
- MUL is unsigned; `sign` is ignored. `Out` = low WIDTH bits of the product; `OFL=1` iff the high WIDTH bits are nonzero.
- Shift ops and logical ops always give `OFL=0`.
- `Zero` = (Out == 0) for every opcode, including logical ops.
- Reserved Op (9–15) → DONE with `Out=0`, `OFL=0`, `Zero=1`, `err=1`. `err=0` for all legal ops.
- Output registers (`Out`, `OFL`, `Zero`, `err`) update only on the transition into DONE.

## Timing
- Reset (`rst` high at an edge), from any state, including mid-multiply:
  - state → IDLE;
  - `Out=0`, `OFL=0`, `Zero=0`, `err=0`, `out_valid=0`;
  - any multiply in flight is discarded;
  - `in_ready=0` while `rst` is high, and 1 in the first cycle after release.
- Non-MUL op accepted at edge N → `out_valid=1` after edge N+1.
- MUL accepted at edge N → exactly WIDTH BUSY cycles → `out_valid=1` after edge N+WIDTH+1.
- Handshake throughput:
  - if `out_ready` is held high, non-MUL throughput is one op per 2 cycles;
  - the result handshake completes on the edge where `out_valid && out_ready`;
  - the next accept occurs no earlier than the following edge.
- `in_ready` is a function of state and `rst` only, never combinational from `in_valid` or `out_ready`.
- `in_valid` in BUSY/DONE is ignored; the upstream stage must hold its bundle.

## Test plan
- ADD signed overflow: A=0x7FFF, B=0x0001, Cin=0, sign=1 → Out=0x8000, OFL=1, Zero=0, `out_valid` 1 cycle after accept.
- Subtract: A=0x0005, B=0x0005, invB=1, Cin=1, sign=0 → Out=0x0000, Zero=1, OFL=1 (carry-out). Repeat with invA=1, invB=0, A=0x0000, B=0x0000 (~0+0+0) → Out=0xFFFF, Zero=0, confirming independent inversion.
- Shifts:
  - ROR 0x8001 by 4 → 0x1800;
  - ROL 0x8001 by 1 → 0x0003;
  - SRA 0x8000 by 15 → 0xFFFF;
  - SLL 0x00FF by 8 → 0xFF00.
- MUL:
  - 0x0100 × 0x0100 → Out=0x0000, OFL=1, Zero=1, `out_valid` exactly 17 cycles after accept, `in_ready` low throughout;
  - 0x00FF × 0x0003 → 0x02FD, OFL=0.
- Backpressure and reset:
  - `out_ready` held low 5 cycles in DONE → outputs stable, `in_ready=0`; raise `out_ready` → IDLE next cycle.
  - `rst` on the 8th BUSY cycle → next cycle `out_valid=0`, all outputs 0, `in_ready=1` after release.
- Reserved op and width: Op=12 → err=1, Out=0, Zero=1. Rerun the ADD and MUL cases with WIDTH=32, SHW=5:
  - 0xFFFFFFFF + 1 → Out=0, OFL=1 (unsigned);
  - MUL latency = 33 cycles.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle execute-stage ALU.
//   Operands are captured with a valid/ready handshake.
//   Rotate, shift, add and logical ops complete in a single cycle.
//   Unsigned multiply runs as an iterative shift-add, one multiplier bit per cycle.
//   The result is held in DONE until the consumer accepts it.
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_valid / in_ready  operand bundle handshake (in_ready depends on state and rst only)
//   A, B, Cin            operands and adder carry-in
//   Op                   0 ROL, 1 SLL, 2 ROR, 3 SRA, 4 ADD, 5 OR, 6 XOR, 7 AND, 8 MUL, 9-15 reserved
//   invA, invB           invert the corresponding operand before use
//   sign                 ADD overflow mode: 1 signed, 0 carry-out
//   out_valid/out_ready  result bundle handshake
//   Out, OFL, Zero, err  result, overflow, Out==0, reserved opcode seen
module alu_mc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [3:0]       Op,
    input  logic             invA,
    input  logic             invB,
    input  logic             sign,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             OFL,
    output logic             Zero,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    typedef enum logic [3:0] {
        OP_ROL = 4'd0,
        OP_SLL = 4'd1,
        OP_ROR = 4'd2,
        OP_SRA = 4'd3,
        OP_ADD = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_AND = 4'd7,
        OP_MUL = 4'd8
    } op_t;

    state_t r_state, w_next;

    logic [WIDTH-1:0]   w_opA, w_opB;
    logic [SHW-1:0]     w_amt, w_amt_neg;
    logic [WIDTH-1:0]   w_rol, w_ror, w_sll, w_sra;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_ofl, w_err;

    logic [2*WIDTH-1:0] r_acc, r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [SHW:0]       r_cnt;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_mul_last;

    logic [WIDTH-1:0]   r_out;
    logic               r_ofl, r_zero, r_err;

    assign w_opA     = invA ? ~A : A;
    assign w_opB     = invB ? ~B : B;
    assign w_amt     = w_opB[SHW-1:0];
    // -amt mod WIDTH; an amount of 0 makes both halves equal to opA, so the OR stays exact.
    assign w_amt_neg = -w_amt;
    assign w_rol     = (w_opA << w_amt) | (w_opA >> w_amt_neg);
    assign w_ror     = (w_opA >> w_amt) | (w_opA << w_amt_neg);
    assign w_sll     = w_opA << w_amt;
    assign w_sra     = $signed(w_opA) >>> w_amt;
    assign w_sum     = {1'b0, w_opA} + {1'b0, w_opB} + {{WIDTH{1'b0}}, Cin};

    always_comb begin
        w_res = '0;
        w_ofl = 1'b0;
        w_err = 1'b0;
        case (Op)
            OP_ROL: w_res = w_rol;
            OP_SLL: w_res = w_sll;
            OP_ROR: w_res = w_ror;
            OP_SRA: w_res = w_sra;
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_ofl = sign ? ((w_opA[WIDTH-1] == w_opB[WIDTH-1]) &&
                                (w_sum[WIDTH-1] != w_opA[WIDTH-1]))
                             : w_sum[WIDTH];
            end
            OP_OR:  w_res = w_opA | w_opB;
            OP_XOR: w_res = w_opA ^ w_opB;
            OP_AND: w_res = w_opA & w_opB;
            OP_MUL: w_res = '0;
            default: w_err = 1'b1;
        endcase
    end

    // The final iteration commits straight from the adder, so DONE follows exactly WIDTH BUSY cycles.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_last = (r_cnt == (SHW+1)'(1));

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid)
                    w_next = (Op == OP_MUL) ? BUSY : DONE;
            end
            BUSY: begin
                if (w_mul_last)
                    w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_out    <= '0;
            r_ofl    <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (Op == OP_MUL) begin
                            r_acc    <= '0;
                            r_mcand  <= {{WIDTH{1'b0}}, w_opA};
                            r_mplier <= w_opB;
                            r_cnt    <= (SHW+1)'(WIDTH);
                        end else begin
                            r_out  <= w_res;
                            r_ofl  <= w_ofl;
                            r_zero <= (w_res == '0);
                            r_err  <= w_err;
                        end
                    end
                end
                BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt - (SHW+1)'(1);
                    if (w_mul_last) begin
                        r_out  <= w_acc_next[WIDTH-1:0];
                        r_ofl  <= |w_acc_next[2*WIDTH-1:WIDTH];
                        r_zero <= (w_acc_next[WIDTH-1:0] == '0);
                        r_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Out  = r_out;
    assign OFL  = r_ofl;
    assign Zero = r_zero;
    assign err  = r_err;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

    typedef struct packed {
        logic [31:0] out;
        logic        ofl;
        logic        zero;
        logic        err;
        logic [7:0]  lat;
        logic        irlow;
        logic        stable;
        logic        back_idle;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv16 = 1'b0, iv32 = 1'b0;
    logic [31:0] A = '0, B = '0;
    logic        Cin = 1'b0, invA = 1'b0, invB = 1'b0, sign = 1'b0;
    logic [3:0]  Op = '0;
    logic        out_ready = 1'b0;

    logic        ir16, ov16, ofl16, zero16, err16;
    logic [15:0] out16;
    logic        ir32, ov32, ofl32, zero32, err32;
    logic [31:0] out32;

    bit          cur_sel = 1'b0;
    logic        m_ov, m_ir, m_ofl, m_zero, m_err;
    logic [31:0] m_out;

    int   errors = 0;
    int   checks = 0;
    res_t sb[$];

    always #5 clk = ~clk;

    alu_mc dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16),
        .A(A[15:0]), .B(B[15:0]), .Cin(Cin), .Op(Op), .invA(invA), .invB(invB),
        .sign(sign), .out_valid(ov16), .out_ready(out_ready),
        .Out(out16), .OFL(ofl16), .Zero(zero16), .err(err16)
    );

    alu_mc #(.WIDTH(32), .SHW(5)) dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32),
        .A(A), .B(B), .Cin(Cin), .Op(Op), .invA(invA), .invB(invB),
        .sign(sign), .out_valid(ov32), .out_ready(out_ready),
        .Out(out32), .OFL(ofl32), .Zero(zero32), .err(err32)
    );

    assign m_ov   = cur_sel ? ov32   : ov16;
    assign m_ir   = cur_sel ? ir32   : ir16;
    assign m_out  = cur_sel ? out32  : {16'h0, out16};
    assign m_ofl  = cur_sel ? ofl32  : ofl16;
    assign m_zero = cur_sel ? zero32 : zero16;
    assign m_err  = cur_sel ? err32  : err16;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t mk(logic [31:0] o, logic f, logic z, logic e, logic [7:0] l);
        res_t r;
        r = '0;
        r.out = o; r.ofl = f; r.zero = z; r.err = e; r.lat = l;
        r.irlow = 1'b1; r.stable = 1'b1; r.back_idle = 1'b1;
        return r;
    endfunction

    function automatic string fmt(res_t r);
        return $sformatf("out=%h ofl=%b zero=%b err=%b lat=%0d irlow=%b stable=%b idle_after=%b",
                         r.out, r.ofl, r.zero, r.err, r.lat, r.irlow, r.stable, r.back_idle);
    endfunction

    // Independent 16-bit reference, written bit-serially where the RTL uses barrel logic.
    function automatic res_t model16(logic [15:0] a, logic [15:0] b, logic cin, logic [3:0] op,
                                     logic ia, logic ib, logic sg);
        logic [15:0] x, y, r;
        logic [16:0] s;
        logic [31:0] p;
        logic        f, e;
        int          n;
        x = ia ? ~a : a;
        y = ib ? ~b : b;
        n = int'(y[3:0]);
        r = x; f = 1'b0; e = 1'b0;
        case (op)
            4'd0: for (int i = 0; i < n; i++) r = {r[14:0], r[15]};
            4'd1: for (int i = 0; i < n; i++) r = {r[14:0], 1'b0};
            4'd2: for (int i = 0; i < n; i++) r = {r[0], r[15:1]};
            4'd3: for (int i = 0; i < n; i++) r = {r[15], r[15:1]};
            4'd4: begin
                s = {1'b0, x} + {1'b0, y} + {16'h0, cin};
                r = s[15:0];
                f = sg ? ((x[15] == y[15]) && (r[15] != x[15])) : s[16];
            end
            4'd5: r = x | y;
            4'd6: r = x ^ y;
            4'd7: r = x & y;
            4'd8: begin
                p = {16'h0, x} * {16'h0, y};
                r = p[15:0];
                f = (p[31:16] != 16'h0);
            end
            default: begin r = '0; e = 1'b1; end
        endcase
        return mk({16'h0, r}, f, (r == 16'h0), e, (op == 4'd8) ? 8'd17 : 8'd1);
    endfunction

    // Drives one bundle into the selected DUT, queues its expectation, and records what comes back.
    task automatic do_op(input bit sel, input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic [3:0] op, input logic ia, input logic ib, input logic sg,
                         input res_t exp, input int hold, output res_t obs);
        int          lat, n;
        logic [34:0] cap;
        cur_sel = sel;
        @(negedge clk);
        A = a; B = b; Cin = cin; Op = op; invA = ia; invB = ib; sign = sg;
        out_ready = 1'b0;
        if (sel) iv32 = 1'b1; else iv16 = 1'b1;
        n = 0;
        while (m_ir !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        sb.push_back(exp);
        @(posedge clk); #1;
        iv16 = 1'b0; iv32 = 1'b0;
        obs = '0;
        obs.irlow = 1'b1;
        lat = 1;
        while (m_ov !== 1'b1 && lat < 100) begin
            if (m_ir !== 1'b0) obs.irlow = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (m_ir !== 1'b0) obs.irlow = 1'b0;
        obs.lat  = (m_ov === 1'b1) ? 8'(lat) : 8'hFF;
        obs.out  = m_out; obs.ofl = m_ofl; obs.zero = m_zero; obs.err = m_err;
        cap = {m_out, m_ofl, m_zero, m_err};
        obs.stable = 1'b1;
        repeat (hold) begin
            @(posedge clk); #1;
            if ({m_out, m_ofl, m_zero, m_err} !== cap || m_ov !== 1'b1 || m_ir !== 1'b0)
                obs.stable = 1'b0;
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        obs.back_idle = (m_ov === 1'b0) && (m_ir === 1'b1);
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ir16, ov16, out16, ofl16, zero16, err16} !== '0) begin
            errors++;
            $display("FAIL reset16: got ir=%b ov=%b out=%h ofl=%b zero=%b err=%b want all 0",
                     ir16, ov16, out16, ofl16, zero16, err16);
        end
        checks++;
        if ({ir32, ov32, out32, ofl32, zero32, err32} !== '0) begin
            errors++;
            $display("FAIL reset32: got ir=%b ov=%b out=%h ofl=%b zero=%b err=%b want all 0",
                     ir32, ov32, out32, ofl32, zero32, err32);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if ({ir16, ir32} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 11", {ir16, ir32});
        end
    endtask

    task automatic test_add;
        res_t obs, e;
        do_op(0, 32'h7FFF, 32'h0001, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1, mk(32'h8000, 1, 0, 0, 1), 0, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL add_signed_ofl: got %s want %s", fmt(obs), fmt(e)); end
    endtask

    task automatic test_sub;
        res_t obs, e;
        do_op(0, 32'h0005, 32'h0005, 1'b1, 4'd4, 1'b0, 1'b1, 1'b0, mk(32'h0000, 1, 1, 0, 1), 0, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL sub_invb: got %s want %s", fmt(obs), fmt(e)); end
        do_op(0, 32'h0000, 32'h0000, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, mk(32'hFFFF, 0, 0, 0, 1), 0, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL sub_inva: got %s want %s", fmt(obs), fmt(e)); end
    endtask

    task automatic test_shifts;
        logic [31:0] ta[4]  = '{32'h8001, 32'h8001, 32'h8000, 32'h00FF};
        logic [31:0] tb[4]  = '{32'd4, 32'd1, 32'd15, 32'd8};
        logic [3:0]  top[4] = '{4'd2, 4'd0, 4'd3, 4'd1};
        logic [31:0] tr[4]  = '{32'h1800, 32'h0003, 32'hFFFF, 32'hFF00};
        res_t obs, e;
        for (int i = 0; i < 4; i++) begin
            do_op(0, ta[i], tb[i], 1'b1, top[i], 1'b0, 1'b0, 1'b1, mk(tr[i], 0, 0, 0, 1), 0, obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin errors++; $display("FAIL shift_%0d: got %s want %s", i, fmt(obs), fmt(e)); end
        end
    endtask

    task automatic test_mul;
        res_t obs, e;
        do_op(0, 32'h0100, 32'h0100, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, mk(32'h0000, 1, 1, 0, 17), 0, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL mul_ovf: got %s want %s", fmt(obs), fmt(e)); end
        do_op(0, 32'h00FF, 32'h0003, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, mk(32'h02FD, 0, 0, 0, 17), 0, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL mul_small: got %s want %s", fmt(obs), fmt(e)); end
    endtask

    task automatic test_reserved;
        res_t obs, e;
        do_op(0, 32'h1234, 32'h5678, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0, mk(32'h0000, 0, 1, 1, 1), 0, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL reserved_op: got %s want %s", fmt(obs), fmt(e)); end
    endtask

    task automatic test_backpressure;
        res_t obs, e;
        do_op(0, 32'h0001, 32'h0002, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, mk(32'h0003, 0, 0, 0, 1), 5, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL backpressure: got %s want %s", fmt(obs), fmt(e)); end
    endtask

    task automatic test_reset_mid_mul;
        int seen;
        cur_sel = 0;
        @(negedge clk);
        A = 32'h0003; B = 32'h0005; Op = 4'd8; invA = 1'b0; invB = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({ir16, ov16, out16, ofl16, zero16, err16} !== '0) begin
            errors++;
            $display("FAIL reset_mid_mul: got ir=%b ov=%b out=%h ofl=%b zero=%b err=%b want all 0",
                     ir16, ov16, out16, ofl16, zero16, err16);
        end
        @(negedge clk); rst = 1'b0; #1;
        checks++;
        if (ir16 !== 1'b1) begin errors++; $display("FAIL reset_mid_mul_ready: got %b want 1", ir16); end
        seen = 0;
        repeat (20) begin @(posedge clk); #1; if (ov16 !== 1'b0) seen++; end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_mid_mul_discard: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_back_to_back;
        int acc;
        cur_sel = 0;
        @(negedge clk);
        A = 32'h0001; B = 32'h0001; Op = 4'd4; Cin = 1'b0; invA = 1'b0; invB = 1'b0; sign = 1'b0;
        out_ready = 1'b1; iv16 = 1'b1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            if (ir16 === 1'b1) acc++;
            @(negedge clk);
        end
        iv16 = 1'b0; out_ready = 1'b0;
        checks++;
        if (acc != 5) begin errors++; $display("FAIL back_to_back_accepts: got %0d want 5", acc); end
        checks++;
        if (out16 !== 16'h0002) begin errors++; $display("FAIL back_to_back_out: got %h want 0002", out16); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_width32;
        res_t obs, e;
        do_op(1, 32'hFFFFFFFF, 32'h00000001, 1'b0, 4'd4, 1'b0, 1'b0, 1'b0, mk(32'h0, 1, 1, 0, 1), 0, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL w32_add: got %s want %s", fmt(obs), fmt(e)); end
        do_op(1, 32'h00010000, 32'h00010000, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0, mk(32'h0, 1, 1, 0, 33), 0, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL w32_mul_ovf: got %s want %s", fmt(obs), fmt(e)); end
        do_op(1, 32'h00012345, 32'h00000010, 1'b0, 4'd8, 1'b0, 1'b0, 1'b1, mk(32'h00123450, 0, 0, 0, 33), 0, obs);
        e = sb.pop_front();
        checks++;
        if (obs !== e) begin errors++; $display("FAIL w32_mul: got %s want %s", fmt(obs), fmt(e)); end
    endtask

    task automatic test_random;
        res_t        obs, e;
        logic [15:0] a, b;
        logic [3:0]  op;
        logic        cin, ia, ib, sg;
        for (int i = 0; i < 24; i++) begin
            a   = 16'($urandom);
            b   = 16'($urandom);
            op  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
            cin = 1'($urandom); ia = 1'($urandom); ib = 1'($urandom); sg = 1'($urandom);
            do_op(0, {16'h0, a}, {16'h0, b}, cin, op, ia, ib, sg, model16(a, b, cin, op, ia, ib, sg), 0, obs);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL random_%0d op=%0d a=%h b=%h: got %s want %s", i, op, a, b, fmt(obs), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_shifts();
        test_mul();
        test_reserved();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        test_width32();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
